// File: rtl/in_chunks.sv
// rtl/in_chunks.sv - reassembles a stream of valid-qualified chunks into words
// with a one-word holding register, gap-timeout abort and sticky overrun.
module in_chunks #(
    parameter int CHUNK_SIZE_BITS = 4,
    parameter int NUM_CHUNKS      = 8,
    parameter int GAP_TIMEOUT     = 4,
    localparam int DATA_SIZE_BITS = NUM_CHUNKS * CHUNK_SIZE_BITS,
    localparam int CNT_W          = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [CHUNK_SIZE_BITS-1:0] in_bits,
    input  logic                       word_ready,
    input  logic                       clear_errors,
    output logic                       word_valid,
    output logic [DATA_SIZE_BITS-1:0]  word_data,
    output logic [CNT_W-1:0]           chunk_count,
    output logic                       overrun,
    output logic                       frame_abort
);

    localparam int GAP_W    = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;
    localparam int GAP_LAST = (GAP_TIMEOUT > 0) ? GAP_TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    logic [CNT_W-1:0]          count_q, count_d;
    logic [DATA_SIZE_BITS-1:0] asm_q, asm_d, asm_ins;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic                      abort_q, abort_d;
    logic                      valid_q, valid_d;
    logic [DATA_SIZE_BITS-1:0] data_q, data_d;
    logic                      over_q, over_d;
    logic                      complete, drop;

    always_comb begin
        asm_ins = asm_q;
        asm_ins[count_q * CHUNK_SIZE_BITS +: CHUNK_SIZE_BITS] = in_bits;

        count_d  = count_q;
        asm_d    = asm_q;
        gap_d    = gap_q;
        abort_d  = 1'b0;
        complete = 1'b0;

        if (in_valid) begin
            gap_d = '0;
            if (count_q == LAST_CHUNK) begin
                complete = 1'b1;
                count_d  = '0;
                asm_d    = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
                asm_d   = asm_ins;
            end
        end else if (GAP_TIMEOUT > 0 && count_q != '0) begin
            // A chunk arriving on the threshold cycle takes the branch above, so it wins.
            if (gap_q == GAP_W'(GAP_LAST)) begin
                count_d = '0;
                asm_d   = '0;
                gap_d   = '0;
                abort_d = 1'b1;
            end else begin
                gap_d = gap_q + GAP_W'(1);
            end
        end else begin
            gap_d = '0;
        end

        valid_d = valid_q;
        data_d  = data_q;
        drop    = 1'b0;
        if (complete) begin
            if (!valid_q || word_ready) begin
                valid_d = 1'b1;
                data_d  = asm_ins;
            end else begin
                drop = 1'b1;
            end
        end else if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end

        over_d = (clear_errors ? 1'b0 : over_q) | drop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            asm_q   <= '0;
            gap_q   <= '0;
            abort_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            over_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            asm_q   <= asm_d;
            gap_q   <= gap_d;
            abort_q <= abort_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            over_q  <= over_d;
        end
    end

    assign word_valid  = valid_q;
    assign word_data   = data_q;
    assign chunk_count = count_q;
    assign overrun     = over_q;
    assign frame_abort = abort_q;

endmodule

// File: doc/in_chunks.md
Name: in_chunks

Overview:
- Receive-side counterpart of the nibble-serial chunk output stream: collects NUM_CHUNKS consecutive CHUNK_SIZE_BITS-wide chunks qualified by a valid strobe and reassembles them into one DATA_SIZE_BITS word.
- Presents each completed word on a valid/ready output interface with a one-word holding register.
- Detects inter-chunk gaps (partial-word abort) and words lost while the holding register is occupied (overrun).

Parameters:
- CHUNK_SIZE_BITS, 4, width of one input chunk.
- NUM_CHUNKS, 8, chunks per word; DATA_SIZE_BITS = NUM_CHUNKS*CHUNK_SIZE_BITS (32).
- GAP_TIMEOUT, 4, consecutive idle cycles mid-word before the partial word is discarded; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_bits carries a chunk this cycle.
- in_bits  input  CHUNK_SIZE_BITS  chunk data, first chunk = least significant.
- word_ready  input  1  consumer accepts word_data when word_valid is high.
- clear_errors  input  1  synchronous clear of the sticky overrun flag.
- word_valid  output  1  word_data holds a completed, unaccepted word.
- word_data  output  DATA_SIZE_BITS  assembled word.
- chunk_count  output  $clog2(NUM_CHUNKS)  chunks collected for the word in progress.
- overrun  output  1  sticky: a completed word was dropped.
- frame_abort  output  1  one-cycle pulse: partial word discarded by gap timeout.

Behaviour:
- Reset (async, active-high): chunk_count=0, shift register=0, word_valid=0, word_data=0, overrun=0, frame_abort=0, gap counter=0. Reset asserted mid-word or mid-hold discards everything. No output is valid until the first clock edge after reset deasserts.
- Assembly: on each posedge with in_valid=1, chunk k (k = chunk_count) is written to bits [k*CHUNK_SIZE_BITS +: CHUNK_SIZE_BITS] of the assembly register, and chunk_count increments.
- Completion: when chunk NUM_CHUNKS-1 is sampled, chunk_count wraps to 0 and the full word (including this chunk) becomes the completed word.
- Completion latency: word_valid rises on the edge that samples the last chunk, so it is visible the cycle after in_valid carried that chunk.
- Back-to-back: a new word may start on the very next cycle; no idle cycle is required between words.
- Output states:
  - EMPTY (word_valid=0): a completed word loads word_data and moves to FULL.
  - FULL (word_valid=1): word_data and word_valid stay stable until a posedge with word_ready=1.
  - Acceptance with no new completion on that edge: go to EMPTY; word_data keeps its last value.
  - Completion and acceptance on the same edge: the new word loads, word_valid stays 1, no overrun.
  - Completion while FULL and word_ready=0: the new word is dropped, word_data is unchanged, overrun is set.
- Assembly never stalls; there is no backpressure toward the sender.
- Gap timeout (GAP_TIMEOUT>0):
  - The gap counter counts consecutive in_valid=0 cycles while chunk_count!=0; it resets on any in_valid=1 and holds at 0 while chunk_count==0.
  - When the counter reaches GAP_TIMEOUT: chunk_count=0, the assembly register is cleared, and frame_abort pulses high for exactly one cycle.
  - An in_valid=1 on the cycle the threshold would be reached wins: the chunk is accepted and there is no abort.
- overrun is sticky. It is cleared by reset or by clear_errors=1 at a posedge. If clear_errors and a new overrun event coincide, the flag stays set.
- word_ready while word_valid=0 is ignored.

Test Plan:
- Reset, then send chunks 4,3,2,1,d,c,b,a on 8 consecutive cycles with word_ready=1 -> word_data=32'habcd1234, word_valid high one cycle after the last chunk for exactly 1 cycle, chunk_count 0..7 then 0.
- word_ready=0, send word 32'h11111111 then 32'h22222222 back-to-back -> word_data stays 32'h11111111, overrun=1. Raise word_ready -> accepted, word_valid=0. Pulse clear_errors -> overrun=0.
- Hold word 32'h11111111 with word_ready=0; raise word_ready on the exact edge the last chunk of 32'h22222222 is sampled -> word_data=32'h22222222, word_valid stays 1, overrun=0.
- Send 3 chunks then idle 4 cycles (GAP_TIMEOUT=4) -> frame_abort 1-cycle pulse, chunk_count=0. The next 8 chunks of 32'hdeadbeef yield exactly that word.
- Send 3 chunks, idle 3 cycles, resume with 5 chunks -> no abort, one word with the chunks in order.
- Assert reset mid-word (after 5 chunks) and while word_valid=1 -> all outputs return to 0 immediately (asynchronously). The next full 8-chunk sequence assembles correctly.
